// File: rtl/bcd_conv_seq_if.sv
// Purpose : handshake/result bundle between a binary producer/result consumer
//           (master) and the iterative binary-to-BCD converter (slave).
// Latency : n/a (wires only).
// Backpr. : start_i/ready_o gate requests, valid_o/ack_i gate results.
// Ports   : start_i, data_i, ack_i driven by master; ready_o, valid_o, bcd_o,
//           overflow_o (and sign_o when BCD_SIGNED_EN is defined) by slave.
interface bcd_conv_seq_if #(
    parameter int DATA_W = 12,
    parameter int DIGITS = 4
);
    logic                  start_i;
    logic [DATA_W-1:0]     data_i;
    logic                  ready_o;
    logic                  valid_o;
    logic                  ack_i;
    logic [4*DIGITS-1:0]   bcd_o;
    logic                  overflow_o;
`ifdef BCD_SIGNED_EN
    logic                  sign_o;
`endif

    modport slave (
        input  start_i,
        input  data_i,
        input  ack_i,
        output ready_o,
        output valid_o,
        output bcd_o,
`ifdef BCD_SIGNED_EN
        output sign_o,
`endif
        output overflow_o
    );

    modport master (
        output start_i,
        output data_i,
        output ack_i,
        input  ready_o,
        input  valid_o,
        input  bcd_o,
`ifdef BCD_SIGNED_EN
        input  sign_o,
`endif
        input  overflow_o
    );
endinterface

// File: rtl/bcd_conv_seq.sv
// Purpose : iterative double-dabble binary-to-BCD converter, one shift per clock.
// Latency : start accepted at edge k -> valid_o high in the cycle after edge k+DATA_W.
// Backpr. : new start only accepted while idle; result held until ack_i is sampled.
// Ports   : clk, rst_n (async, active low), bus (bcd_conv_seq_if.slave):
//           start_i/data_i/ready_o request side, valid_o/ack_i/bcd_o/overflow_o
//           result side. Optional macro BCD_SIGNED_EN: two's-complement input,
//           magnitude converted, sign reported on bus.sign_o.
module bcd_conv_seq #(
    parameter int DATA_W = 12,
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_conv_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [DATA_W-1:0]   bin_q;       // binary bits still to be shifted in
    logic [BCD_W-1:0]    work_q;      // BCD working register
    logic                work_ovf_q;  // sticky: a 1 left the top digit
    logic [CNT_W-1:0]    cnt_q;       // remaining iterations
    logic [BCD_W-1:0]    bcd_q;       // published result
    logic                ovf_q;

    logic                accept;
    logic                last_iter;
    logic [BCD_W-1:0]    adj;
    logic [BCD_W-1:0]    work_shift;
    logic [DATA_W-1:0]   bin_shift;
    logic                carry_out;
    logic [DATA_W-1:0]   load_val;

`ifdef BCD_SIGNED_EN
    logic                load_sign;
    logic                sign_work_q;
    logic                sign_q;

    // Negating DATA_W bits and reading the result unsigned gives the right
    // magnitude even for the most negative value (-2^(DATA_W-1)).
    assign load_sign = bus.data_i[DATA_W-1];
    assign load_val  = load_sign ? (-bus.data_i) : bus.data_i;
`else
    assign load_val  = bus.data_i;
`endif

    // Per-digit +3 correction; each digit is corrected independently, so the
    // low digits stay exact even when higher digits are lost to overflow.
    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_q[4*d +: 4] > 4'd4) begin
                adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
            end else begin
                adj[4*d +: 4] = work_q[4*d +: 4];
            end
        end
    end

    assign carry_out  = adj[BCD_W-1];
    assign work_shift = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
    assign bin_shift  = {bin_q[DATA_W-2:0], 1'b0};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    last_iter = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath. The published result only moves on the final iteration, so
    // nothing partial is ever visible on bcd_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q       <= '0;
            work_q      <= '0;
            work_ovf_q  <= 1'b0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_work_q <= 1'b0;
            sign_q      <= 1'b0;
`endif
        end else if (accept) begin
            bin_q       <= load_val;
            work_q      <= '0;
            work_ovf_q  <= 1'b0;
            cnt_q       <= CNT_W'(DATA_W);
`ifdef BCD_SIGNED_EN
            sign_work_q <= load_sign;
`endif
        end else if (state_q == SHIFT) begin
            bin_q      <= bin_shift;
            work_q     <= work_shift;
            work_ovf_q <= work_ovf_q | carry_out;
            cnt_q      <= cnt_q - CNT_W'(1);
            if (last_iter) begin
                bcd_q  <= work_shift;
                ovf_q  <= work_ovf_q | carry_out;
`ifdef BCD_SIGNED_EN
                sign_q <= sign_work_q;
`endif
            end
        end
    end

    assign bus.ready_o    = (state_q == IDLE);
    assign bus.valid_o    = (state_q == DONE);
    assign bus.bcd_o      = bcd_q;
    assign bus.overflow_o = ovf_q;
`ifdef BCD_SIGNED_EN
    assign bus.sign_o     = sign_q;
`endif
endmodule

// File: tb/tb_bcd_conv_seq.sv
// Purpose : self-checking bench for bcd_conv_seq; drives a 4-digit and a
//           3-digit instance with identical stimulus and compares every cycle
//           against a decimal-arithmetic reference model.
// Latency : n/a.
// Backpr. : exercises delayed ack, held start and ack tied high.
module tb_bcd_conv_seq;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ack;
    logic [DW-1:0] data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_conv_seq_if #(.DATA_W(DW), .DIGITS(4)) bus4 ();
    bcd_conv_seq_if #(.DATA_W(DW), .DIGITS(3)) bus3 ();

    assign bus4.start_i = start;
    assign bus4.data_i  = data;
    assign bus4.ack_i   = ack;
    assign bus3.start_i = start;
    assign bus3.data_i  = data;
    assign bus3.ack_i   = ack;

    bcd_conv_seq #(.DATA_W(DW), .DIGITS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    bcd_conv_seq #(.DATA_W(DW), .DIGITS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [39:0] dec(input longint v, input int nd);
        logic [39:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic too_big(input longint v, input int nd);
        longint lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return (v >= lim);
    endfunction

    function automatic longint mag_of(input logic [DW-1:0] v);
`ifdef BCD_SIGNED_EN
        if (v[DW-1]) return (longint'(1) << DW) - longint'(v);
`endif
        return longint'(v);
    endfunction

    function automatic logic sign_of(input logic [DW-1:0] v);
`ifdef BCD_SIGNED_EN
        return v[DW-1];
`else
        return 1'b0;
`endif
    endfunction

    // Phase: 0 idle, 1 converting, 2 result offered.
    int          m_phase;
    int          m_left;
    longint      m_cap;
    logic        m_cap_sign;
    logic [15:0] e_bcd4;
    logic        e_ovf4;
    logic [11:0] e_bcd3;
    logic        e_ovf3;
    logic        e_sign;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase    <= 0;
            m_left     <= 0;
            m_cap      <= 0;
            m_cap_sign <= 1'b0;
            e_bcd4     <= '0;
            e_ovf4     <= 1'b0;
            e_bcd3     <= '0;
            e_ovf3     <= 1'b0;
            e_sign     <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_cap      <= mag_of(data);
                    m_cap_sign <= sign_of(data);
                    m_left     <= DW;
                    m_phase    <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        e_bcd4  <= 16'(dec(m_cap, 4));
                        e_ovf4  <= too_big(m_cap, 4);
                        e_bcd3  <= 12'(dec(m_cap, 3));
                        e_ovf3  <= too_big(m_cap, 3);
                        e_sign  <= m_cap_sign;
                        m_phase <= 2;
                    end
                end
                default: if (ack) m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("ready4", bus4.ready_o, m_phase == 0);
            check("valid4", bus4.valid_o, m_phase == 2);
            check("bcd4",   bus4.bcd_o, e_bcd4);
            check("ovf4",   bus4.overflow_o, e_ovf4);
            check("ready3", bus3.ready_o, m_phase == 0);
            check("valid3", bus3.valid_o, m_phase == 2);
            check("bcd3",   bus3.bcd_o, e_bcd3);
            check("ovf3",   bus3.overflow_o, e_ovf3);
`ifdef BCD_SIGNED_EN
            check("sign4",  bus4.sign_o, e_sign);
            check("sign3",  bus3.sign_o, e_sign);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk_reset(input string tag);
        check({tag, "_ready"}, bus4.ready_o, 1);
        check({tag, "_valid"}, bus4.valid_o, 0);
        check({tag, "_bcd"},   bus4.bcd_o, 0);
        check({tag, "_ovf"},   bus4.overflow_o, 0);
        check({tag, "_bcd3"},  bus3.bcd_o, 0);
        check({tag, "_ovf3"},  bus3.overflow_o, 0);
`ifdef BCD_SIGNED_EN
        check({tag, "_sign"},  bus4.sign_o, 0);
`endif
    endtask

    // lat counts falling edges after the accepting rising edge until valid_o
    // is seen; valid in the cycle after edge k+DW gives lat = DW+1.
    task automatic conv(input logic [DW-1:0] v, input int ack_dly,
                        input bit hold_start, output int lat);
        @(negedge clk);
        start = 1'b1;
        data  = v;
        @(negedge clk);
        lat = 1;
        if (!hold_start) start = 1'b0;
        while (bus4.valid_o !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus4.valid_o !== 1'b1) check("valid_timeout", 0, 1);
        repeat (ack_dly) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        check("ready_after_ack", bus4.ready_o, 1);
    endtask

    initial begin
        int lat;
        start = 1'b0;
        ack   = 1'b0;
        data  = '0;
        rst_n = 1'b0;

        // Model pins: hand-computed decimal expansions.
        check("pin_dec4095", dec(4095, 4), 40'h4095);
        check("pin_dec1000", dec(1000, 3), 40'h000);
        check("pin_big1000", too_big(1000, 3), 1);
        check("pin_big999",  too_big(999, 3), 0);

        repeat (2) @(negedge clk);
        chk_reset("rst0");
        #3 rst_n = 1'b1;

        conv(12'd4095, 0, 1'b0, lat);
        check("lat_4095", lat, DW + 1);
        check("lit_4095", bus4.bcd_o, 16'h4095);
        check("lit_4095_ovf", bus4.overflow_o, 0);

        conv(12'd0, 1, 1'b0, lat);
        check("lit_0", bus4.bcd_o, 16'h0000);
        conv(12'd999, 0, 1'b0, lat);
        check("lit_999", bus4.bcd_o, 16'h0999);

        // start held high throughout, ack delayed by 5 cycles.
        conv(12'd321, 5, 1'b1, lat);
        check("lat_hold", lat, DW + 1);
        check("lit_321", bus4.bcd_o, 16'h0321);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1;
        data  = 12'd1234;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        #3 rst_n = 1'b1;
        conv(12'd57, 0, 1'b0, lat);
        check("lit_57", bus4.bcd_o, 16'h0057);

        // Three-digit instance overflow, then a small value clears it.
        conv(12'd1000, 0, 1'b0, lat);
        check("lit3_1000", bus3.bcd_o, 12'h000);
        check("lit3_1000_ovf", bus3.overflow_o, 1);
        check("lit4_1000", bus4.bcd_o, 16'h1000);
        conv(12'd5, 2, 1'b0, lat);
        check("lit3_5", bus3.bcd_o, 12'h005);
        check("lit3_5_ovf", bus3.overflow_o, 0);

`ifdef BCD_SIGNED_EN
        conv(12'h800, 0, 1'b0, lat);
        check("lit_s800", bus4.bcd_o, 16'h2048);
        check("lit_s800_sign", bus4.sign_o, 1);
        conv(12'hFFF, 0, 1'b0, lat);
        check("lit_sFFF", bus4.bcd_o, 16'h0001);
        check("lit_sFFF_sign", bus4.sign_o, 1);
`else
        conv(12'h800, 0, 1'b0, lat);
        check("lit_u800", bus4.bcd_o, 16'h2048);
`endif

        // Randomized conversions with random ack delay and start holding.
        for (int i = 0; i < 25; i++) begin
            conv(12'($urandom_range(0, 4095)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), lat);
            check("lat_rand", lat, DW + 1);
        end

        // Back-to-back with ack and start tied high; data churns every cycle.
        @(negedge clk);
        ack   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3 * (DW + 2) + 2; i++) begin
            data = 12'($urandom_range(0, 4095));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (DW + 4) @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_conv_seq.md
# bcd_conv_seq

Iterative (one shift per clock) binary-to-BCD converter with a start/ready and valid/ack handshake. It replaces the flat combinational double-dabble array in the result-display path, so the sequential multiplier's product is converted over DATA_W cycles instead of through a deep adder chain. It sits between the multiplier's result register and the 7-segment digit decoders.

## Interface
- DATA_W, default 12: width of the binary input, 2..32.
- DIGITS, default 4: number of BCD output digits, 1..10.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  conversion request; sampled only while ready_o=1.
- data_i  in  DATA_W  binary value; captured on the accepting edge.
- ready_o  out  1  converter is idle and accepts start_i.
- valid_o  out  1  bcd_o/overflow_o hold a finished result.
- ack_i  in  1  consumer acknowledge; sampled only while valid_o=1.
- bcd_o  out  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
- overflow_o  out  1  result did not fit in DIGITS digits.
- sign_o  out  1  present only with BCD_SIGNED_EN; 1 = negative input.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready_o=1. On a rising edge with start_i=1, the block loads data_i (or its magnitude) into the binary shift register, clears the BCD working register and overflow, sets the bit counter to DATA_W, and goes to SHIFT.
- SHIFT: one iteration per edge.
  - Every working digit > 4 gets +3 (4-bit add, no inter-digit carry).
  - {BCD, binary} then shifts left by 1 bit.
  - A 1 shifted out of the top BCD digit sets sticky overflow.
  - The counter decrements. When the counter reaches 0, the working BCD is copied to bcd_o and the block goes to DONE.
- DONE: valid_o=1. bcd_o, overflow_o and sign_o stay stable until ack_i=1 is sampled, then the block goes to IDLE.
- start_i is ignored in SHIFT and DONE. ack_i is ignored in IDLE and SHIFT.
- bcd_o keeps the last result after ack until the next conversion completes. It is not updated during SHIFT.
- If the value exceeds 10^DIGITS-1, bcd_o holds the low DIGITS digits and overflow_o=1.

## Timing
- Reset values: ready_o=1, valid_o=0, bcd_o=0, overflow_o=0, sign_o=0, state IDLE, counter 0.
- Reset asserted mid-conversion aborts immediately. No partial result is ever presented.
- Latency: start accepted at edge k -> valid_o=1 in the cycle after edge k+DATA_W.
- ready_o=0 from edge k until the edge that samples ack_i. ready_o=1 again in the cycle after the ack edge.
- Back-to-back throughput is DATA_W+2 cycles per conversion when ack_i is tied high.
- ready_o and valid_o are registered-state decodes. They are never both 1.

## Configuration
- BCD_SIGNED_EN defined:
  - data_i is two's complement. The magnitude is taken at capture, and sign_o is the captured MSB.
  - -2^(DATA_W-1) converts correctly, because the magnitude register is DATA_W bits unsigned.
  - sign_o follows the same hold and reset rules as bcd_o.
- BCD_SIGNED_EN undefined: data_i is unsigned and the sign_o port does not exist.

## Test plan
- Default params, data_i=4095, start pulse -> valid_o=1 exactly 12 cycles after the accept edge; bcd_o=16'h4095, overflow_o=0.
- data_i=0 -> bcd_o=16'h0000, overflow_o=0. Then data_i=999 -> bcd_o=16'h0999.
- start_i held high through SHIFT/DONE and ack_i delayed 5 cycles -> no restart, bcd_o stable for all 5 cycles, ready_o=1 one cycle after the ack edge.
- rst_n pulsed low at iteration 6 of a conversion of 1234 -> all outputs return to their reset values asynchronously. A fresh conversion of 57 then yields 16'h0057.
- DIGITS=3, data_i=1000 -> overflow_o=1, bcd_o=12'h000. A following conversion of 5 -> overflow_o=0.
- BCD_SIGNED_EN, data_i=12'h800 -> sign_o=1, bcd_o=16'h2048. data_i=12'hFFF -> sign_o=1, bcd_o=16'h0001.
